// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage core datapath and
// pipeline_hazard_ctrl.
//   master : datapath side. It drives the register ids and the stage
//            status, and receives the stall/flush/forward controls.
//   slave  : controller side, with the opposite directions.
// Optional macro PERF_CNT_EN adds the stall_cycles, flush_cycles and
// wait_cycles counters, each CNT_W bits wide.
interface pipeline_hazard_ctrl_if
`ifdef PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_timeout;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_cycles, wait_cycles;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, mem_timeout
`ifdef PERF_CNT_EN
    , input stall_cycles, flush_cycles, wait_cycles
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, mem_timeout
`ifdef PERF_CNT_EN
    , output stall_cycles, flush_cycles, wait_cycles
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core.
//
// Function:
//   - Drives the stall and flush enables of the F, F->D, D->E and E->M
//     pipeline registers.
//   - Generates the ALU operand forwarding selects.
//   - Resolves load-use, taken-branch and data-memory-wait hazards.
//
// Ports:
//   clk : core clock.
//   rst : synchronous reset, active high.
//   hz  : slave side of pipeline_hazard_ctrl_if.
//
// Optional macro PERF_CNT_EN adds the stall, flush and wait-cycle
// performance counters. Their width is set by parameter CNT_W.
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 15
`ifdef PERF_CNT_EN
  , parameter int CNT_W  = 32
`endif
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  // The counter must be able to hold WAIT_MAX+1, where it saturates.
  localparam int WCW = $clog2(WAIT_MAX + 2);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e         state_q, state_d;
  logic           pend_flush_q, pend_flush_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_timeout_q, mem_timeout_d;
  logic           lw_stall, mem_wait;

  // The Memory stage has priority over Writeback because it holds the
  // younger result. Register x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mem_wait = hz.dmem_req && !hz.dmem_ready;

  always_comb begin
    state_d       = state_q;
    pend_flush_d  = pend_flush_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    hz.StallF     = 1'b0;
    hz.StallD     = 1'b0;
    hz.StallE     = 1'b0;
    hz.StallM     = 1'b0;
    hz.FlushD     = 1'b0;
    hz.FlushE     = 1'b0;
    hz.ForwardAE  = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    hz.ForwardBE  = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    if (rst) begin
      hz.FlushD    = 1'b1;
      hz.FlushE    = 1'b1;
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
    end else begin
      unique case (state_q)
        RUN: begin
          // A memory wait freezes the whole pipe. A branch resolved in the
          // same cycle is remembered and flushed once the wait ends.
          if (mem_wait) begin
            {hz.StallF, hz.StallD, hz.StallE, hz.StallM} = 4'b1111;
            pend_flush_d = hz.PCSrcE;
            wait_cnt_d   = WCW'(1);
            state_d      = MEM_WAIT;
          end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
          end else if (lw_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (hz.dmem_ready) begin
            state_d      = RUN;
            wait_cnt_d   = '0;
            pend_flush_d = 1'b0;
            if (pend_flush_q || hz.PCSrcE) begin
              hz.FlushD = 1'b1;
              hz.FlushE = 1'b1;
            end
          end else begin
            {hz.StallF, hz.StallD, hz.StallE, hz.StallM} = 4'b1111;
            pend_flush_d = pend_flush_q | hz.PCSrcE;
            if (wait_cnt_q != WCW'(WAIT_MAX + 1)) wait_cnt_d = wait_cnt_q + WCW'(1);
            if (wait_cnt_q == WCW'(WAIT_MAX) && mem_wait) mem_timeout_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pend_flush_q  <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_flush_q  <= pend_flush_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hz.mem_timeout = mem_timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cyc_q, wait_cyc_d;

  // The counters wrap naturally. FlushE during rst never reaches them
  // because the clear takes precedence.
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(hz.StallD);
    flush_cnt_d = flush_cnt_q + CNT_W'(hz.FlushE);
    wait_cyc_d  = wait_cyc_q + CNT_W'(state_q == MEM_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cyc_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cyc_q  <= wait_cyc_d;
    end
  end

  assign hz.stall_cycles = stall_cnt_q;
  assign hz.flush_cycles = flush_cnt_q;
  assign hz.wait_cycles  = wait_cyc_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
// It covers forwarding, load-use, branch-over-load, memory wait with a
// pending flush, timeout, and reset in the middle of a wait.
// Control vector layout: ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE}.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if hz ();
  pipeline_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));

  always #5 clk = ~clk;

  logic [5:0] ctl;
  assign ctl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE};

  // Inputs change 2 time units after each rising edge. Checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0; hz.ResultSrcE = 2'b00;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.PCSrcE = 0;
    hz.dmem_req = 0; hz.dmem_ready = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    hz.RdM = 5; hz.RegWriteM = 1; hz.Rs1E = 5;
    tick();
    #1;
    checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, 6'b000011); end
    checks++; if (hz.ForwardAE !== 2'b00) begin errors++; $display("FAIL reset_fwdA got %b want 00", hz.ForwardAE); end
    checks++; if (hz.mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", hz.mem_timeout); end
    rst = 0;
  endtask

  task automatic test_forward();
    idle();
    hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 5;
    #1;
    checks++; if (hz.ForwardAE !== 2'b10) begin errors++; $display("FAIL fwdA_m_wins got %b want 10", hz.ForwardAE); end
    checks++; if (hz.ForwardBE !== 2'b10) begin errors++; $display("FAIL fwdB_m_wins got %b want 10", hz.ForwardBE); end
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL fwd_ctl got %b want 000000", ctl); end
    hz.RdM = 0; hz.Rs2E = 6;
    #1;
    checks++; if (hz.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwdA_rdm0 got %b want 01", hz.ForwardAE); end
    checks++; if (hz.ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdB_nomatch got %b want 00", hz.ForwardBE); end
    hz.RegWriteW = 0;
    #1;
    checks++; if (hz.ForwardAE !== 2'b00) begin errors++; $display("FAIL fwdA_nowrite got %b want 00", hz.ForwardAE); end
  endtask

  task automatic test_lw_stall();
    idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
    #1;
    checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL lw_stall got %b want 110001", ctl); end
    tick();
    // A bubble now occupies Execute, so the stall must release.
    hz.ResultSrcE = 2'b00; hz.RdE = 0;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lw_release got %b want 000000", ctl); end
    hz.ResultSrcE = 2'b01; hz.RdE = 0; hz.Rs2D = 0;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lw_rd0 got %b want 000000", ctl); end
    hz.RdE = 3; hz.Rs1D = 3;
    #1;
    checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL lw_rs1 got %b want 110001", ctl); end
    hz.ResultSrcE = 2'b10;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lw_notload got %b want 000000", ctl); end
    tick();
  endtask

  task automatic test_branch_lw();
    idle();
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs1D = 7; hz.PCSrcE = 1;
    #1;
    checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL branch_over_lw got %b want 000011", ctl); end
    tick();
  endtask

  task automatic test_mem_wait_flush();
    idle();
    rst = 1;
    tick();
    rst = 0;
    hz.dmem_req = 1;
    #1;
    checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_c1 got %b want 111100", ctl); end
    tick();
    hz.PCSrcE = 1;
    #1;
    checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_c2 got %b want 111100", ctl); end
    tick();
    hz.PCSrcE = 0;
    #1;
    checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_c3 got %b want 111100", ctl); end
    tick();
    hz.dmem_ready = 1;
    #1;
    checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL mw_ready got %b want 000011", ctl); end
    tick();
    idle();
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL mw_run got %b want 000000", ctl); end
`ifdef PERF_CNT_EN
    checks++; if (hz.wait_cycles !== 32'd3) begin errors++; $display("FAIL perf_wait got %0d want 3", hz.wait_cycles); end
    checks++; if (hz.flush_cycles !== 32'd1) begin errors++; $display("FAIL perf_flush got %0d want 1", hz.flush_cycles); end
    checks++; if (hz.stall_cycles !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", hz.stall_cycles); end
`endif
  endtask

  task automatic test_rst_mid_wait();
    idle();
    // A memory wait wins over a branch and a load-use hazard in the same cycle.
    hz.dmem_req = 1; hz.PCSrcE = 1; hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs1D = 7;
    #1;
    checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_prio got %b want 111100", ctl); end
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    hz.dmem_req = 1; hz.dmem_ready = 1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL rst_drops_pend got %b want 000000", ctl); end
    tick();
  endtask

  task automatic test_timeout();
    idle();
    hz.dmem_req = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (hz.mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early c%0d got %b want 0", i, hz.mem_timeout); end
      tick();
    end
    #1;
    checks++; if (hz.mem_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b want 1", hz.mem_timeout); end
    checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL to_stall got %b want 111100", ctl); end
    hz.dmem_ready = 1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL to_ready got %b want 000000", ctl); end
    tick();
    idle();
    #1;
    checks++; if (hz.mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", hz.mem_timeout); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (hz.mem_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", hz.mem_timeout); end
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL to_run got %b want 000000", ctl); end
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #2;
    test_reset();
    test_forward();
    test_lw_stall();
    test_branch_lw();
    test_mem_wait_flush();
    test_rst_mid_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
